// File: rtl/ecc_op_scheduler.sv
// ECC coprocessor op scheduler: in-order issue queue feeding NUM_UNITS modular
// arithmetic units, with a backpressured result port, illegal-op and timeout exceptions.
module ecc_op_scheduler #(
    parameter int XLEN      = 64,
    parameter int ID_W      = 4,
    parameter int QDEPTH    = 4,
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [ID_W-1:0]           issue_id_i,
    input  logic [2:0]                issue_funct3_i,
    input  logic [4:0]                issue_rd_i,
    input  logic [XLEN-1:0]           issue_rs1_i,
    input  logic [XLEN-1:0]           issue_rs2_i,
    output logic [NUM_UNITS-1:0]      unit_start_o,
    input  logic [NUM_UNITS-1:0]      unit_done_i,
    input  logic [NUM_UNITS*XLEN-1:0] unit_result_i,
    output logic [XLEN-1:0]           a_o,
    output logic [XLEN-1:0]           b_o,
    output logic [XLEN-1:0]           modulo_o,
    output logic                      modulo_we_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [ID_W-1:0]           result_id_o,
    output logic [4:0]                result_rd_o,
    output logic                      result_we_o,
    output logic [XLEN-1:0]           result_data_o,
    output logic                      result_exc_o,
    output logic                      busy_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t r_state, w_state_nx;

    // issue queue storage (contents need no reset; validity is tracked by r_count)
    logic [ID_W-1:0] r_q_id  [QDEPTH];
    logic [2:0]      r_q_f3  [QDEPTH];
    logic [4:0]      r_q_rd  [QDEPTH];
    logic [XLEN-1:0] r_q_rs1 [QDEPTH];
    logic [XLEN-1:0] r_q_rs2 [QDEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;

    logic [ID_W-1:0] r_op_id;
    logic [2:0]      r_op_f3;
    logic [4:0]      r_op_rd;
    logic [XLEN-1:0] r_op_rs1, r_op_rs2;

    logic [XLEN-1:0] r_a, r_b, r_mod, r_res_data;
    logic            r_res_we, r_res_exc;
    logic [TW-1:0]   r_tcnt;

    logic                 w_push, w_pop, w_mod_we, w_done, w_timeout, w_legal;
    logic [NUM_UNITS-1:0] w_sel, w_start;
    logic [XLEN-1:0]      w_res;
    logic [TW-1:0]        w_tcnt_nx;

    assign issue_ready_o = (r_count != CW'(QDEPTH));
    assign w_push        = issue_valid_i & issue_ready_o;

    // funct3 k selects unit k-1; anything outside 1..NUM_UNITS decodes to no unit
    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_sel
        assign w_sel[k] = (r_op_f3 == 3'(k + 1));
    end

    assign w_legal = |w_sel;
    assign w_done  = |(unit_done_i & w_sel);

    always_comb begin
        w_res = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (w_sel[k]) w_res = unit_result_i[k*XLEN +: XLEN];
        end
    end

    assign w_tcnt_nx = r_tcnt + TW'(1);
    assign w_timeout = (TIMEOUT > 0) && (w_tcnt_nx == TW'(TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_start    = '0;
        w_mod_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != CW'(0)) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_op_f3 == 3'd0) begin
                    w_mod_we   = 1'b1;
                    w_state_nx = S_RESP;
                end else if (w_legal) begin
                    w_start    = w_sel;
                    w_state_nx = S_WAIT;
                end else begin
                    w_state_nx = S_RESP;
                end
            end
            // a done in the timeout cycle still completes normally
            S_WAIT: begin
                if (w_done || w_timeout) w_state_nx = S_RESP;
            end
            S_RESP: begin
                if (result_ready_i) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_id[r_wptr]  <= issue_id_i;
            r_q_f3[r_wptr]  <= issue_funct3_i;
            r_q_rd[r_wptr]  <= issue_rd_i;
            r_q_rs1[r_wptr] <= issue_rs1_i;
            r_q_rs2[r_wptr] <= issue_rs2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op_id    <= '0;
            r_op_f3    <= '0;
            r_op_rd    <= '0;
            r_op_rs1   <= '0;
            r_op_rs2   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_mod      <= '0;
            r_res_data <= '0;
            r_res_we   <= 1'b0;
            r_res_exc  <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op_id  <= r_q_id[r_rptr];
                        r_op_f3  <= r_q_f3[r_rptr];
                        r_op_rd  <= r_q_rd[r_rptr];
                        r_op_rs1 <= r_q_rs1[r_rptr];
                        r_op_rs2 <= r_q_rs2[r_rptr];
                    end
                end
                S_START: begin
                    r_res_data <= '0;
                    r_res_we   <= 1'b0;
                    r_res_exc  <= 1'b0;
                    if (r_op_f3 == 3'd0) begin
                        r_mod <= r_op_rs1;
                    end else if (w_legal) begin
                        r_a    <= r_op_rs1;
                        r_b    <= r_op_rs2;
                        r_tcnt <= '0;
                    end else begin
                        r_res_exc <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_res_data <= w_res;
                        r_res_we   <= 1'b1;
                        r_res_exc  <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_data <= '0;
                        r_res_we   <= 1'b0;
                        r_res_exc  <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unit_start_o   = w_start;
    assign modulo_we_o    = w_mod_we;
    assign a_o            = r_a;
    assign b_o            = r_b;
    assign modulo_o       = r_mod;
    assign result_valid_o = (r_state == S_RESP);
    assign result_id_o    = r_op_id;
    assign result_rd_o    = r_op_rd;
    assign result_we_o    = r_res_we;
    assign result_data_o  = r_res_data;
    assign result_exc_o   = r_res_exc;
    assign busy_o         = (r_count != CW'(0)) || (r_state != S_IDLE);

endmodule

// File: tb/tb_ecc_op_scheduler.sv
// Directed bench for ecc_op_scheduler: behavioural units, scoreboard of expected results.
module tb_ecc_op_scheduler;

    localparam int XLEN = 64, ID_W = 4, QDEPTH = 4, NUM_UNITS = 4, TIMEOUT = 8;

    logic                      clk = 1'b0, rst_i = 1'b1;
    logic                      issue_valid_i = 1'b0, issue_ready_o;
    logic [ID_W-1:0]           issue_id_i = '0;
    logic [2:0]                issue_funct3_i = '0;
    logic [4:0]                issue_rd_i = '0;
    logic [XLEN-1:0]           issue_rs1_i = '0, issue_rs2_i = '0;
    logic [NUM_UNITS-1:0]      unit_start_o, unit_done_i;
    logic [NUM_UNITS*XLEN-1:0] unit_result_i;
    logic [XLEN-1:0]           a_o, b_o, modulo_o, result_data_o;
    logic                      modulo_we_o, result_valid_o, result_ready_i = 1'b0;
    logic [ID_W-1:0]           result_id_o;
    logic [4:0]                result_rd_o;
    logic                      result_we_o, result_exc_o, busy_o;

    ecc_op_scheduler #(.XLEN(XLEN), .ID_W(ID_W), .QDEPTH(QDEPTH),
                       .NUM_UNITS(NUM_UNITS), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_funct3_i(issue_funct3_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .unit_start_o(unit_start_o), .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
        .a_o(a_o), .b_o(b_o), .modulo_o(modulo_o), .modulo_we_o(modulo_we_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_data_o(result_data_o), .result_exc_o(result_exc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic            we;
        logic            exc;
        logic [XLEN-1:0] data;
    } exp_t;
    exp_t sb[$];

    int compared = 0, mismatched = 0;

    function automatic logic [XLEN-1:0] unit_fn(input int k, input logic [XLEN-1:0] a, b);
        case (k)
            0:       return a + b;
            1:       return a - b;
            2:       return a * b;
            default: return a ^ b;
        endcase
    endfunction

    // units compute combinationally from the operand bus; only done timing is modelled
    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
        assign unit_result_i[k*XLEN +: XLEN] = unit_fn(k, a_o, b_o);
    end

    logic [NUM_UNITS-1:0] done_m = '0, stray = '0;
    assign unit_done_i = done_m | stray;
    int unit_lat = 1;
    bit unit_en = 1'b1;
    int pend_u = -1, pend_c = 0;

    always @(posedge clk) begin
        done_m <= '0;
        if (rst_i) begin
            pend_u <= -1;
        end else if (unit_start_o != '0) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (unit_start_o[k]) begin
                    if (unit_lat <= 1) begin
                        if (unit_en) done_m[k] <= 1'b1;
                    end else begin
                        pend_u <= k;
                        pend_c <= unit_lat - 1;
                    end
                end
            end
        end else if (pend_u >= 0) begin
            if (pend_c <= 1) begin
                if (unit_en) done_m[pend_u] <= 1'b1;
                pend_u <= -1;
            end else begin
                pend_c <= pend_c - 1;
            end
        end
    end

    int cyc = 0, mwe_cnt = 0, start_cnt = 0;
    logic [NUM_UNITS-1:0] last_start = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (modulo_we_o) mwe_cnt <= mwe_cnt + 1;
        if (unit_start_o != '0) begin
            start_cnt  <= start_cnt + 1;
            last_start <= unit_start_o;
        end
    end

    int push_cyc = 0, v_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit hang);
        int n = 0;
        exp_t e;
        while (!issue_ready_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("push_ready", issue_ready_o, 1);
        issue_valid_i = 1'b1; issue_id_i = id; issue_funct3_i = f3;
        issue_rd_i = rd; issue_rs1_i = a; issue_rs2_i = b;
        @(posedge clk); #1;
        issue_valid_i = 1'b0;
        push_cyc = cyc;
        e.id = id; e.rd = rd; e.we = 1'b0; e.exc = 1'b0; e.data = '0;
        if (f3 >= 3'd1 && int'(f3) <= NUM_UNITS) begin
            if (hang) e.exc = 1'b1;
            else begin e.we = 1'b1; e.data = unit_fn(int'(f3) - 1, a, b); end
        end else if (f3 != 3'd0) begin
            e.exc = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic get_result(input string tag);
        int n = 0;
        exp_t e;
        while (!result_valid_o && n < 200) begin @(posedge clk); #1; n++; end
        v_cyc = cyc;
        chk({tag, "_valid"}, result_valid_o, 1);
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0 && result_valid_o) begin
            e = sb.pop_front();
            chk({tag, "_id"},   result_id_o,   e.id);
            chk({tag, "_rd"},   result_rd_o,   e.rd);
            chk({tag, "_we"},   result_we_o,   e.we);
            chk({tag, "_exc"},  result_exc_o,  e.exc);
            chk({tag, "_data"}, result_data_o, e.data);
        end
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        chk({tag, "_drop"}, result_valid_o, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},  issue_ready_o,  1);
        chk({tag, "_busy"},   busy_o,         0);
        chk({tag, "_valid"},  result_valid_o, 0);
        chk({tag, "_start"},  unit_start_o,   0);
        chk({tag, "_a"},      a_o,            0);
        chk({tag, "_b"},      b_o,            0);
        chk({tag, "_mod"},    modulo_o,       0);
        chk({tag, "_modwe"},  modulo_we_o,    0);
        chk({tag, "_res"},    {result_id_o, result_rd_o, result_we_o, result_exc_o}, 0);
        chk({tag, "_data"},   result_data_o,  0);
    endtask

    initial begin
        logic [XLEN-1:0] d0, ra, rb;
        int s0, vcnt;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_i = 1'b0;
        @(posedge clk); #1;

        // modulus load
        push(4'd1, 3'd0, 5'd0, 64'hFFFF_FFFF_0000_0001, 64'd0, 1'b0);
        get_result("mod");
        chk("mod_we_pulses", mwe_cnt, 1);
        chk("mod_value", modulo_o, 64'hFFFF_FFFF_0000_0001);

        // minimum latency add
        s0 = start_cnt;
        push(4'd2, 3'd1, 5'd3, 64'd5, 64'd7, 1'b0);
        get_result("add");
        chk("add_latency", 64'(v_cyc - push_cyc), 3);
        chk("add_start_cnt", 64'(start_cnt - s0), 1);
        chk("add_start_vec", last_start, 4'b0001);

        // backpressure: QDEPTH+1 ops with result_ready low
        unit_lat = 3;
        for (int i = 0; i < QDEPTH + 1; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            push(4'(4 + i), 3'((i % NUM_UNITS) + 1), 5'(10 + i), ra, rb, 1'b0);
        end
        chk("bp_full", issue_ready_o, 0);
        chk("bp_busy", busy_o, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_valid_held", result_valid_o, 1);
        d0 = result_data_o;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_data_stable", result_data_o, d0);
        chk("bp_still_full", issue_ready_o, 0);
        for (int i = 0; i < QDEPTH + 1; i++) get_result("bp");
        chk("bp_mod_kept", modulo_o, 64'hFFFF_FFFF_0000_0001);
        unit_lat = 1;

        // illegal funct3 values
        s0 = start_cnt;
        push(4'd9, 3'd7, 5'd4, 64'd1, 64'd2, 1'b0);
        get_result("ill7");
        push(4'd10, 3'd5, 5'd5, 64'd1, 64'd2, 1'b0);
        get_result("ill5");
        chk("ill_no_start", 64'(start_cnt - s0), 0);

        // timeout: exactly TIMEOUT WAIT cycles
        unit_en = 1'b0;
        push(4'd11, 3'd2, 5'd6, 64'd100, 64'd1, 1'b1);
        get_result("tmo");
        chk("tmo_latency", 64'(v_cyc - push_cyc), 2 + TIMEOUT);
        unit_en = 1'b1;
        stray[1] = 1'b1;
        @(posedge clk); #1;
        stray = '0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (result_valid_o) vcnt++;
        end
        chk("tmo_no_stray_result", vcnt, 0);

        // done arriving in the timeout cycle wins
        unit_lat = TIMEOUT;
        push(4'd12, 3'd3, 5'd7, 64'h1234_5678, 64'h10, 1'b0);
        get_result("tie");
        chk("tie_latency", 64'(v_cyc - push_cyc), 2 + TIMEOUT);
        unit_lat = 1;

        // reset in WAIT with two ops queued
        unit_en = 1'b0;
        push(4'd13, 3'd4, 5'd8, 64'd3, 64'd9, 1'b1);
        push(4'd14, 3'd1, 5'd9, 64'd3, 64'd9, 1'b1);
        push(4'd15, 3'd2, 5'd9, 64'd3, 64'd9, 1'b1);
        chk("rst_pre_busy", busy_o, 1);
        chk("rst_pre_valid", result_valid_o, 0);
        #2 rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        unit_en = 1'b1;
        stray[3] = 1'b1;
        @(posedge clk); #1;
        stray = '0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (result_valid_o || busy_o) vcnt++;
        end
        chk("post_rst_quiet", vcnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
